// File: rtl/fpu_ret_pkg.sv
// Shared definitions for the FPU return collector: entry layout, exception
// flag bit positions, source port codes and a small popcount helper.
package fpu_ret_pkg;

  localparam int unsigned FPU_IIW = 10;
  localparam int unsigned RET_W   = 14;

  // Exception flag positions inside ret[5:0]
  localparam int unsigned FLG_INV = 0;
  localparam int unsigned FLG_DEN = 1;
  localparam int unsigned FLG_DVZ = 2;
  localparam int unsigned FLG_OVF = 3;
  localparam int unsigned FLG_UNF = 4;
  localparam int unsigned FLG_INX = 5;

  // Source port codes reported on rt_port
  localparam logic [1:0] PORT_U1 = 2'd0;
  localparam logic [1:0] PORT_U3 = 2'd1;
  localparam logic [1:0] PORT_U5 = 2'd2;

  // Canonical queue entry at the default tag width
  typedef struct packed {
    logic [1:0]         port;
    logic [FPU_IIW-1:0] ii;
    logic [RET_W-1:0]   ret;
  } fpu_ret_ent_t;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/fpu_ret_compact3.sv
// Combinational write compactor for the return queue.
// Ports:
//   i_en   [2:0]  enables in priority order {u5,u3,u1}
//   i_free [CW-1:0] free slots available this cycle (after dequeue)
//   o_acc  [2:0]  enables actually accepted
//   o_off3 / o_off5 slot offsets from wr_ptr for u3 / u5 (u1 is always 0)
//   o_cnt  number of accepted writes (0..3)
//   o_drop at least one enabled return did not fit
module fpu_ret_compact3
  import fpu_ret_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic [2:0]    i_en,
  input  logic [CW-1:0] i_free,
  output logic [2:0]    o_acc,
  output logic [1:0]    o_off3,
  output logic [1:0]    o_off5,
  output logic [1:0]    o_cnt,
  output logic          o_drop
);

  logic [1:0] w_need3;
  logic [1:0] w_need5;
  logic       w_acc1;
  logic       w_acc3;
  logic       w_acc5;

  // Each port needs one more slot than the ports ahead of it already took,
  // so u5 is the first to be cut when space runs short, then u3.
  always_comb begin
    w_acc1  = i_en[0] && (i_free >= CW'(2'd1));
    w_need3 = {1'b0, w_acc1} + 2'd1;
    w_acc3  = i_en[1] && (i_free >= CW'(w_need3));
    w_need5 = {1'b0, w_acc1} + {1'b0, w_acc3} + 2'd1;
    w_acc5  = i_en[2] && (i_free >= CW'(w_need5));
    o_acc   = {w_acc5, w_acc3, w_acc1};
    o_off3  = {1'b0, w_acc1};
    o_off5  = {1'b0, w_acc1} + {1'b0, w_acc3};
    o_cnt   = popcount3({w_acc5, w_acc3, w_acc1});
    o_drop  = |(i_en & ~{w_acc5, w_acc3, w_acc1});
  end

endmodule

// File: rtl/fpu_ret_collect.sv
// FPU return collector: queues up to three completion words per cycle from
// issue ports u1/u3/u5 in arrival order and presents them one per cycle to
// retire over valid/ready. Accumulates sticky exception flags on retire and
// throttles the FP scheduler when the queue is close to full.
// Ports:
//   clk, rst                 clock, async active-high reset
//   u{1,3,5}_ret/_ret_en/_ii return word, qualifier, instruction index
//   flush                    synchronous queue clear
//   flag_clr                 clear sticky flags and ovf_err
//   rt_valid/rt_ready        retire handshake
//   rt_ret/rt_ii/rt_port     head entry (show-ahead)
//   fp_stall                 registered scheduler throttle
//   sticky                   accumulated exception flags
//   ovf_err                  sticky overflow (a return was dropped)
module fpu_ret_collect
  import fpu_ret_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int IIW          = 10,
  parameter int STALL_MARGIN = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [13:0]    u1_ret,
  input  logic           u1_ret_en,
  input  logic [IIW-1:0] u1_ii,
  input  logic [13:0]    u3_ret,
  input  logic           u3_ret_en,
  input  logic [IIW-1:0] u3_ii,
  input  logic [13:0]    u5_ret,
  input  logic           u5_ret_en,
  input  logic [IIW-1:0] u5_ii,
  input  logic           flush,
  input  logic           flag_clr,
  output logic           rt_valid,
  input  logic           rt_ready,
  output logic [13:0]    rt_ret,
  output logic [IIW-1:0] rt_ii,
  output logic [1:0]     rt_port,
  output logic           fp_stall,
  output logic [5:0]     sticky,
  output logic           ovf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_C = CW'(STALL_MARGIN);

  typedef struct packed {
    logic [1:0]     port;
    logic [IIW-1:0] ii;
    logic [13:0]    ret;
  } ent_t;

  ent_t          r_mem [DEPTH];
  logic [CW-1:0] r_wr_ptr;
  logic [CW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_stall;
  logic [5:0]    r_sticky;
  logic          r_ovf;

  logic          w_valid;
  ent_t          w_head;
  logic          w_deq;
  logic [CW-1:0] w_free;
  logic [2:0]    w_en;
  logic [2:0]    w_acc;
  logic [1:0]    w_off3;
  logic [1:0]    w_off5;
  logic [1:0]    w_cnt;
  logic          w_drop;
  logic [CW-1:0] w_count_next;
  logic          w_stall_next;
  logic [5:0]    w_ret_flags;
  logic [5:0]    w_sticky_next;
  logic [AW-1:0] w_wa1;
  logic [AW-1:0] w_wa3;
  logic [AW-1:0] w_wa5;

  // Head view, handshake and free-space computation
  always_comb begin
    w_valid = (r_count != {CW{1'b0}});
    w_head  = r_mem[r_rd_ptr[AW-1:0]];
    // A flush cancels any same-cycle retire, so it never reaches sticky.
    w_deq   = w_valid & rt_ready & ~flush;
    w_free  = DEPTH_C - r_count + CW'(w_deq);
    w_en    = {u5_ret_en, u3_ret_en, u1_ret_en} & {3{~flush}};
  end

  fpu_ret_compact3 #(.CW(CW)) u_compact (
    .i_en   (w_en),
    .i_free (w_free),
    .o_acc  (w_acc),
    .o_off3 (w_off3),
    .o_off5 (w_off5),
    .o_cnt  (w_cnt),
    .o_drop (w_drop)
  );

  // Next-state for occupancy, throttle, flags and write addresses
  always_comb begin
    if (flush) begin
      w_count_next = {CW{1'b0}};
    end else begin
      w_count_next = r_count + CW'(w_cnt) - CW'(w_deq);
    end
    w_stall_next = ((DEPTH_C - w_count_next) <= STALL_C);
    w_ret_flags  = w_deq ? w_head.ret[FLG_INX:FLG_INV] : 6'h00;
    // Clear takes effect before the retiring word's flags are merged.
    if (flag_clr) begin
      w_sticky_next = w_ret_flags;
    end else begin
      w_sticky_next = r_sticky | w_ret_flags;
    end
    w_wa1 = r_wr_ptr[AW-1:0];
    w_wa3 = r_wr_ptr[AW-1:0] + AW'(w_off3);
    w_wa5 = r_wr_ptr[AW-1:0] + AW'(w_off5);
  end

  // Queue storage; contents are qualified by count so no reset is needed
  always_ff @(posedge clk) begin
    if (w_acc[0]) r_mem[w_wa1] <= '{port: PORT_U1, ii: u1_ii, ret: u1_ret};
    if (w_acc[1]) r_mem[w_wa3] <= '{port: PORT_U3, ii: u3_ii, ret: u3_ret};
    if (w_acc[2]) r_mem[w_wa5] <= '{port: PORT_U5, ii: u5_ii, ret: u5_ret};
  end

  // Pointers, occupancy, throttle and sticky status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {CW{1'b0}};
      r_rd_ptr <= {CW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_stall  <= 1'b0;
      r_sticky <= 6'h00;
      r_ovf    <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + CW'(w_cnt);
      if (flush) begin
        r_rd_ptr <= r_wr_ptr;
      end else begin
        r_rd_ptr <= r_rd_ptr + CW'(w_deq);
      end
      r_count  <= w_count_next;
      r_stall  <= w_stall_next;
      r_sticky <= w_sticky_next;
      // A drop in the same cycle as flag_clr keeps the error set.
      r_ovf    <= w_drop | (r_ovf & ~flag_clr);
    end
  end

  // Head fields are forced to zero while the queue is empty
  always_comb begin
    rt_valid = w_valid;
    if (w_valid) begin
      rt_ret  = w_head.ret;
      rt_ii   = w_head.ii;
      rt_port = w_head.port;
    end else begin
      rt_ret  = 14'h0000;
      rt_ii   = {IIW{1'b0}};
      rt_port = 2'd0;
    end
    fp_stall = r_stall;
    sticky   = r_sticky;
    ovf_err  = r_ovf;
  end

endmodule

// File: doc/fpu_ret_collect.md
Name: fpu_ret_collect

Overview:
Receiving end of the FPU return interface. Accepts up to three completion words per cycle from FP issue ports u1/u3/u5, each qualified by ret_en. Words are queued in arrival order and handed to the retire logic one per cycle over a valid/ready handshake. On retire, the block accumulates sticky FP exception flags for fpcsr and throttles the FP scheduler when the queue nears full.

Parameters:
DEPTH, 8, queue entries; power of two, minimum 8
IIW, 10, width of instruction-index tag carried with each return
STALL_MARGIN, 6, stall asserts when free entries <= STALL_MARGIN (two cycles of 3 writes)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
u1_ret  in  14  port-1 return word; [5:0] exception flags {inexact,underflow,overflow,divzero,denorm,invalid}, [13:6] status
u1_ret_en  in  1  u1_ret valid this cycle
u1_ii  in  IIW  port-1 instruction index
u3_ret / u3_ret_en / u3_ii  in  14/1/IIW  same as u1, for port 3
u5_ret / u5_ret_en / u5_ii  in  14/1/IIW  same as u1, for port 5
flush  in  1  synchronous queue clear (pipeline flush)
flag_clr  in  1  clear sticky flags (fpcsr write)
rt_valid  out  1  head entry available
rt_ready  in  1  retire logic accepts head
rt_ret  out  14  head return word
rt_ii  out  IIW  head instruction index
rt_port  out  2  source port of head: 0=u1, 1=u3, 2=u5
fp_stall  out  1  registered throttle to FP scheduler
sticky  out  6  accumulated exception flags
ovf_err  out  1  sticky; a return was dropped for lack of space

Behaviour:
- Reset (async, rst=1): rd/wr pointers=0; count=0; rt_valid=0; rt_ret=0; rt_ii=0; rt_port=0; fp_stall=0; sticky=0; ovf_err=0.
- Storage: DEPTH entries of {port[1:0], ii, ret[13:0]}. Pointers are log2(DEPTH)+1 bits and wrap modulo DEPTH. count ranges 0..DEPTH.
- Enqueue, same cycle:
  - Enabled ports are compacted in fixed order u1, u3, u5 into consecutive slots starting at wr_ptr.
  - Writes per cycle = popcount(u*_ret_en), 0..3.
  - Free space is computed after the same-cycle dequeue: free = DEPTH - count + deq.
  - Enables beyond free space are dropped, lowest priority first (u5, then u3). Each drop sets ovf_err.
- Dequeue: deq = rt_valid & rt_ready.
  - Outputs are driven directly from the head entry (show-ahead).
  - rt_valid = (count != 0), combinational from registered count.
  - Enqueue into an empty queue becomes visible the next cycle; there is no same-cycle bypass. Latency ret_en -> rt_valid = 1 cycle.
- count_next = count + writes - deq.
- fp_stall: registered; fp_stall <= (DEPTH - count_next) <= STALL_MARGIN.
- Sticky flags: sticky <= (sticky | (deq ? rt_ret[5:0] : 0)), gated by flag_clr.
  - If flag_clr and deq occur together, the result is sticky = rt_ret[5:0]: clear first, then OR.
  - ovf_err is cleared only by flag_clr, and a same-cycle drop wins (ovf_err stays 1).
- flush:
  - Sets count=0 and rd_ptr=wr_ptr.
  - Same-cycle enables are discarded, and any same-cycle deq is ignored: no sticky update.
  - fp_stall deasserts next cycle.
  - sticky and ovf_err are unaffected.
- rt_ret, rt_ii and rt_port must hold stable while rt_valid=1 and rt_ready=0.
- Reset mid-operation discards all entries immediately.

Decomposition:
- Shared package fpu_ret_pkg:
  - typedef fpu_ret_ent_t {port, ii, ret}
  - localparams for flag bit positions FLG_INV..FLG_INX
  - port codes PORT_U1/U3/U5
- One sub-module: fpu_ret_compact3. It is combinational; it maps three enables to write-slot offsets and a write count, with free-space truncation.
- The queue RAM, pointers and flag logic stay in the top module.

Test Plan:
1. Reset, then u1_ret_en=1, u1_ret=14'h0011, u1_ii=5, rt_ready=0 -> next cycle rt_valid=1, rt_ret=0x0011, rt_ii=5, rt_port=0; sticky stays 0 until rt_ready=1, then sticky=6'h11.
2. All three enabled in one cycle (ii 1,3,5), rt_ready=1 -> retires in order ii 1,3,5 with rt_port 0,1,2 on three consecutive cycles.
3. rt_ready=0, three writes per cycle for 3 cycles (DEPTH=8) -> fp_stall=1 after cycle 1 (count 3, free 5<=6). Cycle 3 stores only 2: u5 dropped, ovf_err=1, count=8.
4. Full queue with rt_ready=1 and u1_ret_en=1 -> deq frees a slot and the u1 write is accepted; count stays 8; no ovf_err.
5. flag_clr with deq of ret[5:0]=6'h04 while sticky=6'h3F -> sticky=6'h04; then flag_clr alone -> sticky=0.
6. Queue holding 4 entries, flush with u3_ret_en=1 and rt_ready=1 -> next cycle rt_valid=0, count=0, sticky unchanged. Then assert rst mid-write -> all outputs 0 asynchronously.
